// File: rtl/ifetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, flush and occupancy count.
// Flush empties the queue but leaves storage intact; reset also clears storage.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && (cnt != '0);
  // A push into a full queue is allowed only when the head leaves this cycle.
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/ifetch_unit.sv
// RV32I fetch stage: issues word requests, buffers responses with their PCs and
// hands them to decode. Define IFETCH_MISALIGN_CHK_EN for the sticky misaligned-target trap.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESETPC = 32'h0000_0000,
  parameter int          DEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] IMADDR,
  output logic        IMREQ,
  input  logic        IMGNT,
  input  logic        IMRVALID,
  input  logic [31:0] IMRDATA,
  input  logic        PCSRC,
  input  logic [31:0] PCTARGET,
  output logic        IVALID,
  input  logic        IREADY,
  output logic [31:0] INSTR,
  output logic [31:0] PC,
  output logic [31:0] PCPLUS4,
  output logic        MISALIGN
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fpc;
  logic [31:0]   target_load;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] pcq_count;
  logic [CW-1:0] buf_count;
  logic [CW:0]   out_cnt;
  logic [CW:0]   credit;
  logic          grant;
  logic          resp_keep;
  logic          misalign_q;
  logic          buf_pop;
  fetch_entry_t  pcq_din;
  fetch_entry_t  pcq_head;
  fetch_entry_t  buf_din;
  fetch_entry_t  buf_head;

  // In-flight requests are the tracked PCs plus those already marked for discard.
  assign out_cnt = {1'b0, pcq_count} + {1'b0, drop_cnt};
  assign credit  = out_cnt + {1'b0, buf_count};

  assign IMREQ     = !RST && !misalign_q && (credit < (CW + 1)'(DEPTH));
  assign grant     = IMREQ && IMGNT;
  assign resp_keep = IMRVALID && (drop_cnt == '0) && !PCSRC;
  assign buf_pop   = IVALID && IREADY && !PCSRC;

  assign pcq_din = '{pc: fpc, instr: NOP};

  always_comb begin
    buf_din       = pcq_head;
    buf_din.instr = IMRDATA;
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  assign target_load = PCTARGET;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      misalign_q <= 1'b0;
    end else if (PCSRC && (PCTARGET[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign target_load = PCTARGET & ~32'h3;
  assign misalign_q  = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fpc <= RESETPC;
    end else if (PCSRC) begin
      fpc <= target_load;
    end else if (grant) begin
      fpc <= fpc + 32'd4;
    end
  end

  // On redirect every outstanding request, including a same-cycle grant, becomes
  // a discard; a same-cycle response is one of them and is consumed immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_cnt <= '0;
    end else if (PCSRC) begin
      drop_cnt <= CW'(out_cnt + (CW + 1)'(grant) - (CW + 1)'(IMRVALID));
    end else if (IMRVALID && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_pc_queue (
    .clk   (CLK),
    .rst   (RST),
    .push  (grant && !PCSRC),
    .din   (pcq_din),
    .pop   (resp_keep),
    .flush (PCSRC),
    .head  (pcq_head),
    .count (pcq_count)
  );

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fetch_buf (
    .clk   (CLK),
    .rst   (RST),
    .push  (resp_keep),
    .din   (buf_din),
    .pop   (buf_pop),
    .flush (PCSRC),
    .head  (buf_head),
    .count (buf_count)
  );

  assign IMADDR   = fpc;
  assign IVALID   = (buf_count != '0);
  assign INSTR    = buf_head.instr;
  assign PC       = buf_head.pc;
  assign PCPLUS4  = pc_plus4(buf_head.pc);
  assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: in-order memory model with programmable latency,
// decode-side monitor with an expected-PC queue, and hand-timed checks.
module tb_ifetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] IMADDR;
  logic        IMREQ;
  logic        IMGNT = 1'b0;
  logic        IMRVALID = 1'b0;
  logic [31:0] IMRDATA = '0;
  logic        PCSRC = 1'b0;
  logic [31:0] PCTARGET = '0;
  logic        IVALID;
  logic        IREADY = 1'b0;
  logic [31:0] INSTR;
  logic [31:0] PC;
  logic [31:0] PCPLUS4;
  logic        MISALIGN;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int cyc      = 0;
  int n_grant  = 0;
  int waited;

  logic [31:0] exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  ifetch_unit #(
    .RESETPC (32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IMADDR   (IMADDR),
    .IMREQ    (IMREQ),
    .IMGNT    (IMGNT),
    .IMRVALID (IMRVALID),
    .IMRDATA  (IMRDATA),
    .PCSRC    (PCSRC),
    .PCTARGET (PCTARGET),
    .IVALID   (IVALID),
    .IREADY   (IREADY),
    .INSTR    (INSTR),
    .PC       (PC),
    .PCPLUS4  (PCPLUS4),
    .MISALIGN (MISALIGN)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hDEAD_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic ready);
    @(negedge CLK);
    RST    = 1'b1;
    PCSRC  = 1'b0;
    IMGNT  = 1'b1;
    IREADY = ready;
    exp_q.delete();
    #3;
    check("rst_imreq", 32'(IMREQ), 32'd0);
    check("rst_ivalid", 32'(IVALID), 32'd0);
    check("rst_instr", INSTR, 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_pcplus4", PCPLUS4, 32'h4);
    check("rst_misalign", 32'(MISALIGN), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST     = 1'b0;
    n_grant = 0;
  endtask

  task automatic redirect(input logic [31:0] target);
    PCSRC    = 1'b1;
    PCTARGET = target;
    exp_q.delete();
  endtask

  // ---------------- memory model (in order, fixed latency) ----------------
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (RST) begin
        mq_addr.delete();
        mq_due.delete();
        IMRVALID = 1'b0;
      end else begin
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
          IMRVALID = 1'b1;
          IMRDATA  = mem_word(mq_addr[0]);
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end else begin
          IMRVALID = 1'b0;
          IMRDATA  = '0;
        end
        if (IMREQ && IMGNT) begin
          mq_addr.push_back(IMADDR);
          mq_due.push_back(cyc + mem_lat);
          n_grant++;
          if (!PCSRC) exp_q.push_back(IMADDR);
        end
      end
      cyc++;
    end
  end

  // ---------------- scoreboard: every accepted instruction ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (!RST && IVALID === 1'b1 && IREADY && !PCSRC) begin
        check("pop_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pop_pc", PC, e);
          check("pop_instr", INSTR, mem_word(e));
          check("pop_pcplus4", PCPLUS4, e + 32'd4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Straight-line fetch, 1-cycle memory.
    mem_lat = 1;
    do_reset(1'b1);
    #3;
    check("t1_req_first", 32'(IMREQ), 32'd1);
    check("t1_addr0", IMADDR, 32'h0);
    check("t1_ivalid0", 32'(IVALID), 32'd0);
    @(negedge CLK); #3;
    check("t1_addr1", IMADDR, 32'h4);
    check("t1_ivalid1", 32'(IVALID), 32'd0);
    @(negedge CLK); #3;
    check("t1_ivalid2", 32'(IVALID), 32'd1);
    check("t1_pc", PC, 32'h0);
    check("t1_instr", INSTR, mem_word(32'h0));
    check("t1_addr2", IMADDR, 32'h8);
    check("t1_credit_full", 32'(IMREQ), 32'd0);
    repeat (12) @(negedge CLK);

    // Decode stalled: credits run out after DEPTH grants.
    do_reset(1'b0);
    repeat (10) @(negedge CLK);
    #3;
    check("t2_grants", 32'(n_grant), 32'd2);
    check("t2_req_off", 32'(IMREQ), 32'd0);
    check("t2_ivalid", 32'(IVALID), 32'd1);
    check("t2_head", PC, 32'h0);
    @(negedge CLK);
    IREADY = 1'b1;
    #3;
    check("t2_drain0", PC, 32'h0);
    @(negedge CLK); #3;
    check("t2_drain1", PC, 32'h4);
    check("t2_req_resume", 32'(IMREQ), 32'd1);
    check("t2_addr_resume", IMADDR, 32'h8);
    repeat (6) @(negedge CLK);

    // 3-cycle memory, redirect with two requests outstanding.
    mem_lat = 3;
    do_reset(1'b1);
    @(negedge CLK);
    @(negedge CLK);
    redirect(32'h0000_0100);
    #3;
    check("t3_req_out2", 32'(IMREQ), 32'd0);
    @(negedge CLK);
    PCSRC = 1'b0;
    #3;
    check("t3_addr_tgt", IMADDR, 32'h100);
    check("t3_ivalid_off", 32'(IVALID), 32'd0);
    check("t3_req_wait", 32'(IMREQ), 32'd0);
    waited = 0;
    while (IVALID !== 1'b1 && waited < 20) begin
      @(negedge CLK); #3;
      waited++;
    end
    check("t3_wait", 32'(waited), 32'd5);
    check("t3_pc", PC, 32'h100);
    check("t3_pcplus4", PCPLUS4, 32'h104);
    check("t3_instr", INSTR, mem_word(32'h100));
    repeat (8) @(negedge CLK);

    // Redirect coinciding with a response and a decode handshake.
    mem_lat = 1;
    do_reset(1'b1);
    @(negedge CLK);
    @(negedge CLK);
    redirect(32'h0000_0200);
    #3;
    check("t4_ivalid_pre", 32'(IVALID), 32'd1);
    @(negedge CLK);
    PCSRC = 1'b0;
    #3;
    check("t4_flushed", 32'(IVALID), 32'd0);
    check("t4_addr_tgt", IMADDR, 32'h200);
    check("t4_req", 32'(IMREQ), 32'd1);
    @(negedge CLK); #3;
    check("t4_ivalid_t2", 32'(IVALID), 32'd0);
    @(negedge CLK); #3;
    check("t4_ivalid_t3", 32'(IVALID), 32'd1);
    check("t4_pc", PC, 32'h200);
    repeat (6) @(negedge CLK);

    // Address wrap at 2^32, redirect in the first cycle after reset.
    do_reset(1'b1);
    redirect(32'hFFFF_FFFC);
    @(negedge CLK);
    PCSRC = 1'b0;
    #3;
    check("t5_addr_top", IMADDR, 32'hFFFF_FFFC);
    check("t5_req", 32'(IMREQ), 32'd1);
    @(negedge CLK); #3;
    check("t5_addr_wrap", IMADDR, 32'h0);
    @(negedge CLK); #3;
    check("t5_ivalid", 32'(IVALID), 32'd1);
    check("t5_pc", PC, 32'hFFFF_FFFC);
    check("t5_pcplus4", PCPLUS4, 32'h0);
    repeat (6) @(negedge CLK);

    // Misaligned redirect target.
    do_reset(1'b1);
    redirect(32'h0000_0102);
    @(negedge CLK);
    PCSRC = 1'b0;
    #3;
`ifdef IFETCH_MISALIGN_CHK_EN
    check("t6_misalign", 32'(MISALIGN), 32'd1);
    check("t6_req_off", 32'(IMREQ), 32'd0);
    check("t6_addr_raw", IMADDR, 32'h102);
    repeat (6) @(negedge CLK);
    #3;
    check("t6_sticky", 32'(MISALIGN), 32'd1);
    check("t6_req_held", 32'(IMREQ), 32'd0);
    check("t6_ivalid", 32'(IVALID), 32'd0);
    do_reset(1'b1);
    #3;
    check("t6_req_after_rst", 32'(IMREQ), 32'd1);
    check("t6_misalign_clr", 32'(MISALIGN), 32'd0);
`else
    check("t6_addr_aligned", IMADDR, 32'h100);
    check("t6_misalign", 32'(MISALIGN), 32'd0);
    @(negedge CLK);
    @(negedge CLK); #3;
    check("t6_ivalid", 32'(IVALID), 32'd1);
    check("t6_pc", PC, 32'h100);
`endif
    repeat (4) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
